// File: rtl/int_to_fp32_conv.sv
// Integer (signed/unsigned, IN_WIDTH bits) to IEEE-754 single converter, bit-serial normaliser.
// Build option: define INT2FP_ROUND_EN for round-to-nearest-even, otherwise truncation.
module int_to_fp32_conv #(
  parameter int IN_WIDTH  = 32,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [31:0]         out_data,
  output logic                out_inexact,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int LZW = $clog2(IN_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] mag_q, mag_d;
  logic [LZW-1:0]      lz_q, lz_d;
  logic                sign_q, sign_d;
  logic [31:0]         data_q, data_d;
  logic                inex_q, inex_d;

  logic                sign_in;
  logic [62:0]         al;
  logic [22:0]         frac_t;
  logic                guard, sticky, round_up, carry;
  logic [23:0]         frac_r;
  logic [7:0]          exp_v;

  assign sign_in = SIGNED_IN & in_data[IN_WIDTH-1];

  // Left-align mag into 63 bits, dropping the implicit leading one; bits below W are zero padding.
  always_comb begin
    al     = 63'(mag_q) << (64 - IN_WIDTH);
    frac_t = al[62:40];
    guard  = al[39];
    sticky = |al[38:0];
`ifdef INT2FP_ROUND_EN
    round_up = guard & (sticky | frac_t[0]);
`else
    round_up = 1'b0;
`endif
    frac_r = {1'b0, frac_t} + 24'(round_up);
    carry  = frac_r[23];
    exp_v  = 8'(127 + IN_WIDTH - 1) - 8'(lz_q) + 8'(carry);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_d = NORM;
      NORM: begin
        if (mag_q == '0)                state_d = OUT;
        else if (mag_q[IN_WIDTH-1])     state_d = ROUND;
      end
      ROUND: state_d = OUT;
      OUT:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == OUT);
    out_data    = data_q;
    out_inexact = inex_q;
  end

  always_comb begin
    mag_d  = mag_q;
    lz_d   = lz_q;
    sign_d = sign_q;
    data_d = data_q;
    inex_d = inex_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          mag_d  = sign_in ? -in_data : in_data;
          lz_d   = '0;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          data_d = '0;
          inex_d = 1'b0;
        end else if (!mag_q[IN_WIDTH-1]) begin
          mag_d = mag_q << 1;
          lz_d  = lz_q + LZW'(1);
        end
      end
      ROUND: begin
        data_d = {sign_q, exp_v, frac_r[22:0]};
        inex_d = guard | sticky;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mag_q  <= '0;
      lz_q   <= '0;
      sign_q <= 1'b0;
      data_q <= '0;
      inex_q <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      lz_q   <= lz_d;
      sign_q <= sign_d;
      data_q <= data_d;
      inex_q <= inex_d;
    end
  end

endmodule

// File: tb/tb_int_to_fp32_conv.sv
// Bench for int_to_fp32_conv: directed vector table, backpressure/reset sequences, random vs. arithmetic model.
module tb_int_to_fp32_conv;

  logic CLK;
  logic RST;
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0] din  [3];
  logic        vin  [3];
  logic        ordy [3];
  logic [31:0] dout [3];
  logic        inex [3];
  logic        ov   [3];
  logic        ir   [3];

  int n_cmp = 0;
  int n_err = 0;

`ifdef INT2FP_ROUND_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  int_to_fp32_conv #(.IN_WIDTH(32), .SIGNED_IN(1'b1)) u_s32 (
    .CLK(CLK), .RST(RST), .in_data(din[0][31:0]), .in_valid(vin[0]), .in_ready(ir[0]),
    .out_data(dout[0]), .out_inexact(inex[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  int_to_fp32_conv #(.IN_WIDTH(32), .SIGNED_IN(1'b0)) u_u32 (
    .CLK(CLK), .RST(RST), .in_data(din[1][31:0]), .in_valid(vin[1]), .in_ready(ir[1]),
    .out_data(dout[1]), .out_inexact(inex[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  int_to_fp32_conv #(.IN_WIDTH(16), .SIGNED_IN(1'b0)) u_u16 (
    .CLK(CLK), .RST(RST), .in_data(din[2][15:0]), .in_valid(vin[2]), .in_ready(ir[2]),
    .out_data(dout[2]), .out_inexact(inex[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic int width_of(input int idx);
    return (idx == 2) ? 16 : 32;
  endfunction

  // Reference: exact magnitude, MSB position, remainder compared with half an ULP.
  function automatic void ref_conv(input logic [63:0] raw, input int w, input bit s,
                                   output logic [31:0] f, output bit ix, output int lat);
    logic [63:0] v, mag, kept, rem, half;
    int p, e, sh;
    bit neg;
    v    = raw & ((64'd1 << w) - 64'd1);
    neg  = s && v[w-1];
    mag  = neg ? ((64'd1 << w) - v) : v;
    ix   = 1'b0;
    f    = '0;
    lat  = 2;
    if (mag == 64'd0) return;
    p = 63;
    while (!mag[p]) p--;
    lat = 3 + (w - 1 - p);
    e   = 127 + p;
    if (p <= 23) begin
      kept = mag << (23 - p);
    end else begin
      sh   = p - 23;
      kept = mag >> sh;
      rem  = mag - (kept << sh);
      half = 64'd1 << (sh - 1);
      ix   = (rem != 64'd0);
      if (RNE && ((rem > half) || (rem == half && kept[0]))) kept = kept + 64'd1;
      if (kept == (64'd1 << 24)) begin
        kept = kept >> 1;
        e++;
      end
    end
    f = {neg, 8'(e), kept[22:0]};
  endfunction

  task automatic run_op(input int idx, input logic [63:0] data, input int hold,
                        output logic [31:0] got, output bit gix, output int lat);
    @(negedge CLK);
    din[idx] = data;
    vin[idx] = 1'b1;
    chk("in_ready_idle", 64'(ir[idx]), 64'd1);
    @(posedge CLK); #1;
    vin[idx] = 1'b0;
    lat = 1;
    while (!ov[idx] && lat < 200) begin
      @(posedge CLK); #1;
      lat++;
    end
    got = dout[idx];
    gix = inex[idx];
    if (!ov[idx]) begin
      chk("out_valid_timeout", 64'(ov[idx]), 64'd1);
      return;
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge CLK);
      din[idx] = ~data;
      vin[idx] = 1'b1;
      chk("hold_in_ready", 64'(ir[idx]), 64'd0);
      chk("hold_out_valid", 64'(ov[idx]), 64'd1);
      chk("hold_out_data", 64'(dout[idx]), 64'(got));
      chk("hold_inexact", 64'(inex[idx]), 64'(gix));
    end
    @(negedge CLK);
    vin[idx]  = 1'b0;
    ordy[idx] = 1'b1;
    @(posedge CLK); #1;
    ordy[idx] = 1'b0;
    chk("post_hs_valid", 64'(ov[idx]), 64'd0);
    chk("post_hs_ready", 64'(ir[idx]), 64'd1);
  endtask

  typedef struct {
    int          idx;
    logic [63:0] data;
    logic [31:0] f_rne;
    logic [31:0] f_trn;
    bit          ix;
    int          lat;
  } vec_t;

  vec_t vt[10];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, ef;
    bit          gix, eix;
    int          lat, elat;

    vt[0] = '{0, 64'h00000000, 32'h00000000, 32'h00000000, 1'b0, 2};
    vt[1] = '{0, 64'h00000001, 32'h3F800000, 32'h3F800000, 1'b0, 34};
    vt[2] = '{0, 64'hFFFFFFFF, 32'hBF800000, 32'hBF800000, 1'b0, 34};
    vt[3] = '{0, 64'h7FFFFFFF, 32'h4F000000, 32'h4EFFFFFF, 1'b1, 4};
    vt[4] = '{0, 64'h80000000, 32'hCF000000, 32'hCF000000, 1'b0, 3};
    vt[5] = '{1, 64'h80000000, 32'h4F000000, 32'h4F000000, 1'b0, 3};
    vt[6] = '{0, 64'h01000001, 32'h4B800000, 32'h4B800000, 1'b1, 10};
    vt[7] = '{2, 64'h0000FFFF, 32'h477FFF00, 32'h477FFF00, 1'b0, 3};
    vt[8] = '{0, 64'h01000003, 32'h4B800002, 32'h4B800001, 1'b1, 10};
    vt[9] = '{0, 64'h00FFFFFF, 32'h4B7FFFFF, 32'h4B7FFFFF, 1'b0, 11};

    for (int i = 0; i < 3; i++) begin
      din[i]  = '0;
      vin[i]  = 1'b0;
      ordy[i] = 1'b0;
    end
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_out_data", 64'(dout[0]), 64'd0);
    chk("rst_inexact", 64'(inex[0]), 64'd0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].idx, vt[i].data, 0, got, gix, lat);
      chk($sformatf("vec%0d_data", i), 64'(got), 64'(RNE ? vt[i].f_rne : vt[i].f_trn));
      chk($sformatf("vec%0d_inexact", i), 64'(gix), 64'(vt[i].ix));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].lat));
    end

    // Backpressure: result held 5 cycles, fresh in_valid during hold must be ignored.
    run_op(0, 64'h12345678, 5, got, gix, lat);
    ref_conv(64'h12345678, 32, 1'b1, ef, eix, elat);
    chk("bp_data", 64'(got), 64'(ef));
    chk("bp_inexact", 64'(gix), 64'(eix));

    // Reset mid-NORM aborts the operation.
    @(negedge CLK);
    din[0] = 64'h1;
    vin[0] = 1'b1;
    @(posedge CLK); #1;
    vin[0] = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("norm_busy_ready", 64'(ir[0]), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_out_valid", 64'(ov[0]), 64'd0);
    chk("abort_in_ready", 64'(ir[0]), 64'd1);
    chk("abort_out_data", 64'(dout[0]), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    run_op(0, 64'h3, 0, got, gix, lat);
    chk("after_rst_data", 64'(got), 64'h40400000);
    chk("after_rst_latency", 64'(lat), 64'd33);

    for (int n = 0; n < 150; n++) begin
      int          idx;
      logic [63:0] data;
      int          hold;
      idx  = $urandom_range(0, 2);
      data = {$urandom(), $urandom()} >> $urandom_range(0, 63);
      hold = $urandom_range(0, 2);
      run_op(idx, data, hold, got, gix, lat);
      ref_conv(data, width_of(idx), (idx == 0), ef, eix, elat);
      chk($sformatf("rnd%0d_u%0d_%0h_data", n, idx, data), 64'(got), 64'(ef));
      chk($sformatf("rnd%0d_u%0d_%0h_inexact", n, idx, data), 64'(gix), 64'(eix));
      chk($sformatf("rnd%0d_u%0d_%0h_latency", n, idx, data), 64'(lat), 64'(elat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
